weight_shadow_loader: RTL
=========================

WEIGHT_SHADOW_LOADER -- requirements
Module: weight_shadow_loader

Interface
REQ-001 The block SHALL have parameter MATRIX_WIDTH, default 14, giving the systolic array edge length (rows and bytes per row).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port enable, input, 1 bit: global stall; when low, all state SHALL be held.
REQ-005 The block SHALL have port load_weight, input, 1 bit: a weight row is present this cycle.
REQ-006 The block SHALL have port weight_addr, input, byte_type: target shadow row index.
REQ-007 The block SHALL have port is_weight_signed, input, 1 bit: signedness of the presented row.
REQ-008 The block SHALL have port weight_data, input, MATRIX_WIDTH x byte_type: row payload.
REQ-009 The block SHALL have port activate, input, 1 bit: request to swap the shadow set into the active set.
REQ-010 The block SHALL have port active_weights, output, MATRIX_WIDTH x MATRIX_WIDTH x byte_type: weights driven to the MAC array.
REQ-011 The block SHALL have port active_signed, output, 1 bit: signedness of active_weights.
REQ-012 The block SHALL have port shadow_full, output, 1 bit: all MATRIX_WIDTH shadow rows are valid.
REQ-013 The block SHALL have port swap_done, output, 1 bit: one-cycle pulse, swap accepted.
REQ-014 The block SHALL have port swap_reject, output, 1 bit: one-cycle pulse, activate refused.
REQ-015 The block SHALL have port load_error, output, 1 bit: one-cycle pulse, bad row address or signedness mismatch.

Function
REQ-016 On an enabled edge with load_weight=1 and weight_addr<MATRIX_WIDTH, the block SHALL write weight_data to shadow row weight_addr and set that row's valid bit.
REQ-017 The block SHALL accept a rewrite of an already-valid row: data replaced, no error.
REQ-018 If weight_addr>=MATRIX_WIDTH, the block SHALL discard the row and pulse load_error on the next cycle.
REQ-019 The first accepted row of a set SHALL latch shadow_signed; a later row with a different is_weight_signed SHALL be written, keep the latched value, and pulse load_error.
REQ-020 The state machine SHALL have states EMPTY (no valid rows), FILLING (1..MATRIX_WIDTH-1 valid rows) and FULL (all valid); shadow_full=1 exactly in FULL.
REQ-021 On an enabled edge with activate=1 in FULL, the block SHALL copy all shadow rows to active_weights, copy shadow_signed to active_signed, clear all valid bits, and pulse swap_done in the following cycle.
REQ-022 On an enabled edge with activate=1 outside FULL, the block SHALL leave all state unchanged and pulse swap_reject in the following cycle.
REQ-023 With activate and a valid load_weight on the same enabled edge in FULL, the swap SHALL take the pre-write shadow contents, and the incoming row SHALL become the sole valid row of the new set (next state FILLING, shadow_signed from that row).
REQ-024 With MATRIX_WIDTH=1 under REQ-023, the next state SHALL be FULL.
REQ-025 Pulse outputs SHALL be registered and last exactly one clock cycle; a pulse pending when enable goes low SHALL be held until the next enabled edge, then deasserted.
REQ-026 The latency from the last accepted row to shadow_full=1 SHALL be one cycle; from accepted activate to the new active_weights SHALL be one cycle.

Reset
REQ-027 With rst_n=0, the block SHALL immediately clear active_weights, active_signed, shadow rows, shadow_signed, the valid mask and all pulse outputs, and enter EMPTY.
REQ-028 A reset asserted mid-fill or in the activate cycle SHALL abort the operation: no swap_done, and active_weights SHALL be zero after release.

Structure
REQ-029 The weight row type (MATRIX_WIDTH x byte_type) and the loader state enumeration SHALL be in tpu_pkg; byte_type SHALL be reused from it.
REQ-030 The block SHALL be a single module with no sub-modules.

Verification (MATRIX_WIDTH=14)
REQ-031 Load rows 0..13 with data row r, bytes = r, signed=1, then activate -> shadow_full=1 one cycle after row 13, swap_done pulse, active row 5 = all 0x05, active_signed=1, shadow_full=0.
REQ-032 Load rows 0..12 only, then activate -> swap_reject pulse, active_weights unchanged (zero), state FILLING.
REQ-033 load_weight with weight_addr=14 -> load_error pulse, valid mask unchanged.
REQ-034 Row 0 signed=0, row 1 signed=1 -> load_error pulse; after full set and activate, active_signed=0.
REQ-035 In FULL, activate together with row 3 = 0xAA -> active row 3 holds old data, shadow has only row 3 valid, state FILLING.
REQ-036 rst_n low for one cycle after row 7 of a fill -> all outputs zero, EMPTY, with no clock edge required.

Source files
------------

// File: rtl/tpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tpu_pkg
//  Description : Shared TPU types: byte lanes, weight rows, loader FSM states.
//  Revision    : 1.0  initial release
// ============================================================================
package tpu_pkg;

    typedef logic [7:0] byte_type;

    localparam int TPU_MATRIX_WIDTH = 14;

    typedef byte_type [TPU_MATRIX_WIDTH-1:0] weight_row_type;

    typedef enum logic [1:0] {
        LOADER_EMPTY   = 2'd0,
        LOADER_FILLING = 2'd1,
        LOADER_FULL    = 2'd2
    } loader_state_e;

endpackage
`default_nettype wire

// File: rtl/weight_shadow_loader.sv
`default_nettype none
// ============================================================================
//  Module      : weight_shadow_loader
//  Description : Double-buffered weight store; rows fill a shadow set that is
//                swapped into the active set feeding the MAC array.
//  Revision    : 1.0  initial release
// ============================================================================
module weight_shadow_loader
    import tpu_pkg::*;
#(
    parameter int MATRIX_WIDTH = 14
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        enable,
    input  logic                                        load_weight,
    input  byte_type                                    weight_addr,
    input  logic                                        is_weight_signed,
    input  byte_type [MATRIX_WIDTH-1:0]                 weight_data,
    input  logic                                        activate,
    output byte_type [MATRIX_WIDTH-1:0][MATRIX_WIDTH-1:0] active_weights,
    output logic                                        active_signed,
    output logic                                        shadow_full,
    output logic                                        swap_done,
    output logic                                        swap_reject,
    output logic                                        load_error
);

    typedef byte_type [MATRIX_WIDTH-1:0] row_t;

    loader_state_e              r_state;
    loader_state_e              w_state_next;
    logic [MATRIX_WIDTH-1:0]    r_valid;
    logic [MATRIX_WIDTH-1:0]    w_valid_next;
    row_t [MATRIX_WIDTH-1:0]    r_shadow;
    row_t [MATRIX_WIDTH-1:0]    w_shadow_next;
    logic                       r_shadow_signed;
    logic                       w_shadow_signed_next;
    row_t [MATRIX_WIDTH-1:0]    r_active;
    logic                       r_active_signed;
    logic                       r_swap_done;
    logic                       r_swap_reject;
    logic                       r_load_error;

    logic                       w_addr_ok;
    logic                       w_addr_bad;
    logic                       w_swap;
    logic                       w_reject;
    logic                       w_sign_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= LOADER_EMPTY;
        end else if (enable) begin
            r_state <= w_state_next;
        end
    end

    // The swap clears the mask before the same-edge write lands, so a row
    // arriving with activate starts the next set and sets its signedness.
    always_comb begin
        w_addr_ok            = load_weight && (int'(weight_addr) < MATRIX_WIDTH);
        w_addr_bad           = load_weight && !w_addr_ok;
        w_swap               = activate && (r_state == LOADER_FULL);
        w_reject             = activate && (r_state != LOADER_FULL);
        w_valid_next         = w_swap ? '0 : r_valid;
        w_shadow_next        = r_shadow;
        w_shadow_signed_next = r_shadow_signed;
        w_sign_err           = 1'b0;
        w_state_next         = r_state;

        if (w_addr_ok) begin
            if (w_valid_next == '0) begin
                w_shadow_signed_next = is_weight_signed;
            end else if (is_weight_signed != r_shadow_signed) begin
                w_sign_err = 1'b1;
            end
            for (int i = 0; i < MATRIX_WIDTH; i++) begin
                if (weight_addr == byte_type'(i)) begin
                    w_shadow_next[i] = weight_data;
                    w_valid_next[i]  = 1'b1;
                end
            end
        end

        if (w_valid_next == '0) begin
            w_state_next = LOADER_EMPTY;
        end else if (&w_valid_next) begin
            w_state_next = LOADER_FULL;
        end else begin
            w_state_next = LOADER_FILLING;
        end
    end

    // Pulses update only on enabled edges, so a stall holds them unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid         <= '0;
            r_shadow        <= '0;
            r_shadow_signed <= 1'b0;
            r_active        <= '0;
            r_active_signed <= 1'b0;
            r_swap_done     <= 1'b0;
            r_swap_reject   <= 1'b0;
            r_load_error    <= 1'b0;
        end else if (enable) begin
            r_valid         <= w_valid_next;
            r_shadow        <= w_shadow_next;
            r_shadow_signed <= w_shadow_signed_next;
            if (w_swap) begin
                r_active        <= r_shadow;
                r_active_signed <= r_shadow_signed;
            end
            r_swap_done     <= w_swap;
            r_swap_reject   <= w_reject;
            r_load_error    <= w_addr_bad | w_sign_err;
        end
    end

    assign active_weights = r_active;
    assign active_signed  = r_active_signed;
    assign shadow_full    = (r_state == LOADER_FULL);
    assign swap_done      = r_swap_done;
    assign swap_reject    = r_swap_reject;
    assign load_error     = r_load_error;

endmodule
`default_nettype wire
